pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Program-counter stage directly upstream of the Fetch stage: owns the F-stage PC register,
//   selects next PC (sequential, branch/jump redirect from D), holds on stall and captures
//   redirects arriving during a stall. Drives pc_o into Fetch's PC field. Flags fetch addresses
//   outside instruction memory and freezes the front end until reset.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value after reset
//   IM_BASE   32'h0000_3000  byte address of IM word 0
//   IM_WORDS  4096           IM depth in 32-bit words; legal PC range [IM_BASE, IM_BASE+4*IM_WORDS)
// PORTS
//   clk                 in   1   rising-edge clock
//   rst_n               in   1   reset, asynchronous, active-low
//   stall_i             in   1   hazard unit: hold PC this cycle
//   redirect_valid_i    in   1   one-cycle pulse from D: branch taken / j / jal / jr
//   redirect_target_i   in   32  redirect byte address
//   pc_o                out  32  current fetch PC (to Fetch)
//   pc_plus8_o          out  32  pc_o + 8, link value for jal/jalr
//   pending_o           out  1   redirect latched, not yet applied
//   addr_err_o          out  1   sticky: illegal fetch address reached
//   fetch_cnt_o         out  32  number of PC advances since reset
// BEHAVIOUR
//   Reset (async assert, sync-to-clk release): pc_o=RESET_PC, pending_o=0, addr_err_o=0,
//     fetch_cnt_o=0, state=RUN, pending target reg=0. pc_plus8_o is combinational from pc_o.
//   States: RUN (no pending), PEND (redirect latched), ERR (frozen). Encoded 2 bits; 2'b11 -> ERR.
//   Delay-slot semantics: redirect seen at edge N makes PC at N+1 = target; instr in F during
//     the redirect cycle is the delay slot and is never killed.
//   Next-state priority per edge (RUN/PEND):
//     1. stall_i=1: PC holds, fetch_cnt holds. If redirect_valid_i: pend_tgt<=target, ->PEND
//        (a newer redirect overwrites an older pending one).
//     2. redirect_valid_i=1: PC<=target, ->RUN, pending cleared (live beats pending).
//     3. state==PEND: PC<=pend_tgt, ->RUN.
//     4. else PC<=PC+4 (mod 2^32).
//     Cases 2-4: fetch_cnt_o += 1 (wraps at 2^32).
//   Legality check on the PC being loaded (cases 2-4): illegal if addr[1:0]!=0, addr<IM_BASE,
//     or addr>=IM_BASE+4*IM_WORDS (compute bound in 33 bits; no overflow aliasing).
//     Illegal -> PC not updated, ->ERR, addr_err_o<=1, fetch_cnt not incremented.
//   ERR: all inputs ignored, outputs frozen until rst_n low. pending_o=0 in ERR.
//   pending_o = (state==PEND). Stall with no redirect in PEND keeps PEND and pend_tgt.
//   Sequential end of IM: PC=IM_BASE+4*IM_WORDS-4 (0x6FFC default) +4 -> ERR, pc_o stays 0x6FFC.
//   rst_n low mid-stall or in PEND/ERR: immediate return to reset values, pending target lost.
//   Single clock domain; no combinational path from inputs to pc_o.
// TESTING
//   Reset release, 3 free-run cycles -> pc_o 0x3000,0x3004,0x3008,0x300C; fetch_cnt_o=3.
//   PC=0x3010, redirect 0x3100 pulse, no stall -> next pc_o=0x3100, pending_o stays 0.
//   PC=0x3020, stall=1 + redirect 0x3200 pulse, stall held 2 more cycles -> pc_o 0x3020,
//     pending_o=1 for 3 cycles; stall drops -> pc_o=0x3200, pending_o=0, fetch_cnt +1 only.
//   PEND with 0x3200, stall drops same cycle as redirect 0x3400 -> pc_o=0x3400 (live wins).
//   Redirect to 0x3002, to 0x2FFC, and free-run past 0x6FFC -> addr_err_o=1, pc_o frozen at
//     prior value, further redirects ignored; rst_n pulse -> pc_o=0x3000, addr_err_o=0.
//   rst_n asserted asynchronously mid-cycle while in PEND -> outputs reset before next edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter stage feeding Fetch: sequential advance, delay-slot redirects,
// stall hold with redirect capture, and a sticky freeze on illegal fetch addresses.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus8_o,
  output logic        pending_o,
  output logic        addr_err_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PEND = 2'b01,
    ST_ERR  = 2'b11
  } state_t;

  // Upper bound kept in 33 bits so a window ending at 2^32 cannot alias to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {IM_WORDS[30:0], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_fetch_cnt;
  logic        r_addr_err;

  logic [31:0] w_cand;
  logic        w_legal;

  // Candidate PC for a non-stalled edge: live redirect, then pending, then sequential.
  always_comb begin
    // NOTE: default first so every path assigns w_cand and no latch is inferred.
    w_cand = r_pc + 32'd4;
    if (redirect_valid_i)
      w_cand = redirect_target_i;
    else if (r_state == ST_PEND)
      w_cand = r_pend_tgt;
  end

  assign w_legal = (w_cand[1:0] == 2'b00) && (w_cand >= IM_BASE) &&
                   ({1'b0, w_cand} < IM_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_pend_tgt  <= '0;
      r_fetch_cnt <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      if (r_state != ST_ERR) begin
        if (stall_i) begin
          if (redirect_valid_i) begin
            r_pend_tgt <= redirect_target_i;
            r_state    <= ST_PEND;
          end
        end else if (w_legal) begin
          r_pc        <= w_cand;
          r_state     <= ST_RUN;
          r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end else begin
          r_state    <= ST_ERR;
          r_addr_err <= 1'b1;
        end
      end
    end
  end

  assign pc_o        = r_pc;
  assign pc_plus8_o  = r_pc + 32'd8;
  assign pending_o   = (r_state == ST_PEND);
  assign addr_err_o  = r_addr_err;
  assign fetch_cnt_o = r_fetch_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the PC rules.
module tb_pc_unit;

  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus8_o;
  logic        pending_o;
  logic        addr_err_o;
  logic [31:0] fetch_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic [31:0] m_cnt;
  bit          m_pend;
  bit          m_err;

  pc_unit #(
    .RESET_PC (RESET_PC),
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .pc_o              (pc_o),
    .pc_plus8_o        (pc_plus8_o),
    .pending_o         (pending_o),
    .addr_err_o        (addr_err_o),
    .fetch_cnt_o       (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= IM_BASE) &&
           (longint'(a) < longint'(IM_BASE) + 4 * longint'(IM_WORDS));
  endfunction

  function automatic void model_reset();
    m_pc = RESET_PC; m_tgt = 0; m_cnt = 0; m_pend = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit s, input bit rv, input logic [31:0] t);
    logic [31:0] nxt;
    if (m_err) return;
    if (s) begin
      if (rv) begin m_pend = 1; m_tgt = t; end
      return;
    end
    if (rv)          nxt = t;
    else if (m_pend) nxt = m_tgt;
    else             nxt = m_pc + 4;
    m_pend = 0;
    if (legal(nxt)) begin m_pc = nxt; m_cnt = m_cnt + 1; end
    else            m_err = 1;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"},      pc_o,        m_pc);
    check({tag, ".plus8"},   pc_plus8_o,  m_pc + 32'd8);
    check({tag, ".pending"}, 32'(pending_o),  32'(m_pend));
    check({tag, ".err"},     32'(addr_err_o), 32'(m_err));
    check({tag, ".cnt"},     fetch_cnt_o, m_cnt);
  endtask

  // Called at posedge+1: drive inputs, take one edge, update model, compare.
  task automatic step(input string tag, input bit s, input bit rv, input logic [31:0] t);
    stall_i = s; redirect_valid_i = rv; redirect_target_i = t;
    @(posedge clk);
    model_step(s, rv, t);
    #1;
    check_all(tag);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases at posedge+1.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    stall_i = 0; redirect_valid_i = 0; redirect_target_i = 0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 0; redirect_valid_i = 0; redirect_target_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset");

    // Free run from reset
    step("run1", 0, 0, 0);
    step("run2", 0, 0, 0);
    step("run3", 0, 0, 0);
    check("run3.spec_pc", pc_o, 32'h300C);
    check("run3.spec_cnt", fetch_cnt_o, 32'd3);
    step("run4", 0, 0, 0);
    check("run4.spec_pc", pc_o, 32'h3010);

    // Plain redirect
    step("redir", 0, 1, 32'h3100);
    check("redir.spec_pc", pc_o, 32'h3100);
    step("to3020", 0, 1, 32'h3020);

    // Redirect captured during a 3-cycle stall
    step("st0", 1, 1, 32'h3200);
    step("st1", 1, 0, 0);
    step("st2", 1, 0, 0);
    check("st2.spec_pc", pc_o, 32'h3020);
    check("st2.spec_pend", 32'(pending_o), 32'd1);
    step("st_rel", 0, 0, 0);
    check("st_rel.spec_pc", pc_o, 32'h3200);

    // Newer stalled redirect overwrites older, then live beats pending
    step("ow0", 1, 1, 32'h3300);
    step("ow1", 1, 1, 32'h3200);
    step("live", 0, 1, 32'h3400);
    check("live.spec_pc", pc_o, 32'h3400);
    step("seq", 0, 0, 0);

    // Async reset while pending
    step("pend", 1, 1, 32'h3500);
    do_reset("rst_pend");
    step("post_rst", 0, 0, 0);

    // Misaligned redirect
    step("mis", 0, 1, 32'h3002);
    check("mis.spec_err", 32'(addr_err_o), 32'd1);
    step("mis_ign", 0, 1, 32'h3100);
    step("mis_ign2", 1, 1, 32'h3100);
    do_reset("rst_mis");

    // Below base, via a pending redirect
    step("lo0", 1, 1, 32'h2FFC);
    step("lo1", 0, 0, 0);
    do_reset("rst_lo");

    // Sequential walk off the end of IM
    step("end0", 0, 1, 32'h6FF8);
    step("end1", 0, 0, 0);
    step("end2", 0, 0, 0);
    check("end2.spec_pc", pc_o, 32'h6FFC);
    step("end3", 0, 0, 0);
    do_reset("rst_end");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit s, rv;
      logic [31:0] t;
      s  = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 19) == 0) t = $urandom();
      else if ($urandom_range(0, 9) == 0) t = 32'h6FF0 + ($urandom_range(0, 3) << 2);
      else t = IM_BASE + ($urandom_range(0, IM_WORDS - 1) << 2);
      step("rnd", s, rv, t);
      if (m_err && $urandom_range(0, 7) == 0) do_reset("rnd_rst");
      else if ($urandom_range(0, 299) == 0) do_reset("rnd_rst2");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
